vgm_sva_expect_sched: RTL and testbench

Shared-checker scheduler for the SVA unit-test utilities. Up to NUM_REQ test requesters compete for one assertion checker. The block grants the checker round-robin, arms it, and watches its pass/fail pulses within a per-request timeout window. It then reports a single result per check and mirrors the outcome on sticky `pass_called`/`fail_called` flags, which tests read without referencing variables inside `expect` action blocks.

---
 rtl/vgm_sva_expect_sched.sv | 175 +++++++++++++++++
 tb/tb_vgm_sva_expect_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vgm_sva_expect_sched.sv
// Shared assertion-checker scheduler: round-robin grant, arm, timed pass/fail watch,
// single registered result per check plus sticky pass/fail flags.
module vgm_sva_expect_sched #(
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT_W = 8,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*TIMEOUT_W-1:0]   req_timeout,
    input  logic                           checker_pass,
    input  logic                           checker_fail,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           arm,
    output logic                           busy,
    output logic                           done,
    output logic [ID_W-1:0]                done_id,
    output logic [1:0]                     result,
    output logic                           pass_called,
    output logic                           fail_called
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_REPORT
    } state_t;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_PASS    = 2'b01;
    localparam logic [1:0] RES_FAIL    = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    state_t               state, state_nxt;
    logic [ID_W-1:0]      last_id, last_id_nxt;
    logic [ID_W-1:0]      id, id_nxt;
    logic [TIMEOUT_W-1:0] t_lat, t_lat_nxt;
    logic [TIMEOUT_W-1:0] cnt, cnt_nxt;
    logic [NUM_REQ-1:0]   gnt_r, gnt_nxt;
    logic                 arm_r, arm_nxt;
    logic                 busy_r, busy_nxt;
    logic                 done_r, done_nxt;
    logic [ID_W-1:0]      done_id_r, done_id_nxt;
    logic [1:0]           result_r, result_nxt;
    logic                 pass_r, pass_nxt;
    logic                 fail_r, fail_nxt;

    logic                 pick_valid;
    logic [ID_W-1:0]      pick_id;
    logic [TIMEOUT_W-1:0] pick_t;

    // Round-robin search starts just after the last winner, so it has lowest priority.
    // NOTE: every always_comb output gets a default first; a missed path would infer a latch.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!pick_valid && req[ID_W'((int'(last_id) + i) % NUM_REQ)]) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'((int'(last_id) + i) % NUM_REQ);
            end
        end
        pick_t = req_timeout[int'(pick_id)*TIMEOUT_W +: TIMEOUT_W];
    end

    always_comb begin
        state_nxt   = state;
        last_id_nxt = last_id;
        id_nxt      = id;
        t_lat_nxt   = t_lat;
        cnt_nxt     = cnt;
        gnt_nxt     = gnt_r;
        arm_nxt     = 1'b0;
        busy_nxt    = busy_r;
        done_nxt    = 1'b0;
        done_id_nxt = done_id_r;
        result_nxt  = result_r;
        pass_nxt    = pass_r;
        fail_nxt    = fail_r;

        unique case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    state_nxt        = S_ARM;
                    id_nxt           = pick_id;
                    last_id_nxt      = pick_id;
                    t_lat_nxt        = pick_t;
                    gnt_nxt          = '0;
                    gnt_nxt[pick_id] = 1'b1;
                    arm_nxt          = 1'b1;
                    busy_nxt         = 1'b1;
                    pass_nxt         = 1'b0;
                    fail_nxt         = 1'b0;
                end
            end
            S_ARM: begin
                state_nxt = S_WAIT;
                cnt_nxt   = t_lat;
            end
            S_WAIT: begin
                // Fail outranks pass, but a coincident pass still sets its own flag.
                if (checker_fail) begin
                    fail_nxt   = 1'b1;
                    pass_nxt   = pass_r | checker_pass;
                    result_nxt = RES_FAIL;
                end else if (checker_pass) begin
                    pass_nxt   = 1'b1;
                    result_nxt = RES_PASS;
                end else if (cnt == '0) begin
                    result_nxt = RES_TIMEOUT;
                end else begin
                    cnt_nxt = cnt - TIMEOUT_W'(1);
                end
                if (checker_fail || checker_pass || cnt == '0) begin
                    state_nxt   = S_REPORT;
                    done_nxt    = 1'b1;
                    done_id_nxt = id;
                end
            end
            S_REPORT: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            last_id   <= ID_W'(NUM_REQ - 1);
            id        <= '0;
            t_lat     <= '0;
            cnt       <= '0;
            gnt_r     <= '0;
            arm_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            done_id_r <= '0;
            result_r  <= RES_NONE;
            pass_r    <= 1'b0;
            fail_r    <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_id   <= last_id_nxt;
            id        <= id_nxt;
            t_lat     <= t_lat_nxt;
            cnt       <= cnt_nxt;
            gnt_r     <= gnt_nxt;
            arm_r     <= arm_nxt;
            busy_r    <= busy_nxt;
            done_r    <= done_nxt;
            done_id_r <= done_id_nxt;
            result_r  <= result_nxt;
            pass_r    <= pass_nxt;
            fail_r    <= fail_nxt;
        end
    end

    assign gnt         = gnt_r;
    assign arm         = arm_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign done_id     = done_id_r;
    assign result      = result_r;
    assign pass_called = pass_r;
    assign fail_called = fail_r;

endmodule

// File: tb/tb_vgm_sva_expect_sched.sv
// Directed bench for vgm_sva_expect_sched: one task per scenario, hand-computed expectations.
module tb_vgm_sva_expect_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_timeout;
    logic        checker_pass;
    logic        checker_fail;
    logic [3:0]  gnt;
    logic        arm;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic [1:0]  result;
    logic        pass_called;
    logic        fail_called;

    int tests = 0;
    int fails = 0;

    vgm_sva_expect_sched #(.NUM_REQ(4), .TIMEOUT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_timeout  (req_timeout),
        .checker_pass (checker_pass),
        .checker_fail (checker_fail),
        .gnt          (gnt),
        .arm          (arm),
        .busy         (busy),
        .done         (done),
        .done_id      (done_id),
        .result       (result),
        .pass_called  (pass_called),
        .fail_called  (fail_called)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_timeout = '0; checker_pass = 1'b0; checker_fail = 1'b0;
        tick(); tick();
        tests++;
        if ({gnt, arm, busy, done, done_id, result, pass_called, fail_called} !== 13'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %b exp %b",
                     {gnt, arm, busy, done, done_id, result, pass_called, fail_called}, 13'h0);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_pass();
        req = 4'b0100; req_timeout[2*8 +: 8] = 8'd5;
        tick();  // cycle 1
        req = '0;
        tests++;
        if ({gnt, arm, busy} !== 6'b0100_1_1) begin
            fails++; $display("FAIL pass_arm: got %b exp %b", {gnt, arm, busy}, 6'b0100_1_1);
        end
        tick();  // cycle 2
        tests++;
        if ({arm, done} !== 2'b00) begin
            fails++; $display("FAIL pass_arm_pulse: got %b exp %b", {arm, done}, 2'b00);
        end
        tick();  // cycle 3
        tick();  // cycle 4
        checker_pass = 1'b1;
        tick();  // cycle 5
        checker_pass = 1'b0;
        tests++;
        if ({done, done_id, result, pass_called, fail_called, gnt} !== 11'b1_10_01_1_0_0100) begin
            fails++;
            $display("FAIL pass_done: got %b exp %b",
                     {done, done_id, result, pass_called, fail_called, gnt}, 11'b1_10_01_1_0_0100);
        end
        tick();  // cycle 6
        tests++;
        if ({done, busy, gnt, result} !== 8'b0_0_0000_01) begin
            fails++; $display("FAIL pass_idle: got %b exp %b", {done, busy, gnt, result}, 8'b0_0_0000_01);
        end
    endtask

    task automatic test_simultaneous();
        req = 4'b0010; req_timeout[1*8 +: 8] = 8'd4; checker_pass = 1'b1;
        tick();  // cycle 1, ARM
        req = '0;
        tests++;
        if ({gnt, pass_called, fail_called} !== 6'b0010_0_0) begin
            fails++; $display("FAIL sim_arm_clear: got %b exp %b", {gnt, pass_called, fail_called}, 6'b0010_0_0);
        end
        tick();  // cycle 2, WAIT
        checker_pass = 1'b0;
        tests++;
        if ({pass_called, fail_called, done} !== 3'b000) begin
            fails++; $display("FAIL sim_ignore_early: got %b exp %b", {pass_called, fail_called, done}, 3'b000);
        end
        tick();  // cycle 3
        checker_pass = 1'b1; checker_fail = 1'b1;
        tick();  // cycle 4
        checker_pass = 1'b0; checker_fail = 1'b0;
        tests++;
        if ({done, done_id, result, pass_called, fail_called} !== 7'b1_01_10_1_1) begin
            fails++;
            $display("FAIL sim_done: got %b exp %b",
                     {done, done_id, result, pass_called, fail_called}, 7'b1_01_10_1_1);
        end
        tick();  // cycle 5, IDLE
    endtask

    task automatic test_timeout(input logic [7:0] t, input int done_cyc, input string tag);
        req = 4'b0001; req_timeout[0 +: 8] = t;
        tick();  // cycle 1
        req = '0;
        tests++;
        if (gnt !== 4'b0001) begin
            fails++; $display("FAIL %s_gnt: got %b exp %b", tag, gnt, 4'b0001);
        end
        for (int c = 2; c < done_cyc; c++) tick();
        tests++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL %s_early: got done=%b exp 0", tag, done);
        end
        tick();  // done_cyc
        tests++;
        if ({done, done_id, result, pass_called, fail_called} !== 7'b1_00_11_0_0) begin
            fails++;
            $display("FAIL %s_done: got %b exp %b", tag,
                     {done, done_id, result, pass_called, fail_called}, 7'b1_00_11_0_0);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b1111; req_timeout = 32'h0707_0707; checker_pass = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();  // ARM at 1+4k
            tests++;
            if ({gnt, arm} !== {exp_gnt[k], 1'b1}) begin
                fails++; $display("FAIL rr_gnt_%0d: got %b exp %b", k, {gnt, arm}, {exp_gnt[k], 1'b1});
            end
            tick(); tick();  // done at 3+4k
            tests++;
            if ({done, done_id, result} !== {1'b1, exp_id[k], 2'b01}) begin
                fails++;
                $display("FAIL rr_done_%0d: got %b exp %b", k, {done, done_id, result}, {1'b1, exp_id[k], 2'b01});
            end
            if (k == 4) begin
                req = '0; checker_pass = 1'b0;
            end
            tick();  // IDLE at 4+4k
            tests++;
            if (done !== 1'b0) begin
                fails++; $display("FAIL rr_pulse_%0d: got done=%b exp 0", k, done);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int saw_done = 0;
        req = 4'b0010; req_timeout[1*8 +: 8] = 8'd10;
        tick();  // cycle 1
        req = '0;
        tests++;
        if (gnt !== 4'b0010) begin
            fails++; $display("FAIL rst_mid_gnt: got %b exp %b", gnt, 4'b0010);
        end
        tick();  // cycle 2
        tick();  // cycle 3
        rst = 1'b1;
        tick();  // cycle 4
        rst = 1'b0;
        tests++;
        if ({gnt, arm, busy, done, done_id, result, pass_called, fail_called} !== 13'h0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got %b exp %b",
                     {gnt, arm, busy, done, done_id, result, pass_called, fail_called}, 13'h0);
        end
        for (int c = 0; c < 14; c++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) saw_done++;
        end
        tests++;
        if (saw_done != 0) begin
            fails++; $display("FAIL rst_mid_no_done: got %0d active cycles exp 0", saw_done);
        end
        req = 4'b0011; req_timeout[0 +: 8] = 8'd0;
        tick();  // cycle 1
        req = '0;
        tests++;
        if (gnt !== 4'b0001) begin
            fails++; $display("FAIL rst_mid_regrant: got %b exp %b", gnt, 4'b0001);
        end
        tick(); tick();  // cycle 3
        tests++;
        if ({done, done_id, result} !== 5'b1_00_11) begin
            fails++; $display("FAIL rst_mid_done: got %b exp %b", {done, done_id, result}, 5'b1_00_11);
        end
        tick();
    endtask

    task automatic test_request_drop();
        req = 4'b1000; req_timeout[3*8 +: 8] = 8'd2;
        tick();  // cycle 1
        tests++;
        if (gnt !== 4'b1000) begin
            fails++; $display("FAIL drop_gnt: got %b exp %b", gnt, 4'b1000);
        end
        tick();  // cycle 2
        req = '0;
        tick(); tick();  // cycle 4, last WAIT
        tests++;
        if ({busy, gnt} !== 5'b1_1000) begin
            fails++; $display("FAIL drop_hold: got %b exp %b", {busy, gnt}, 5'b1_1000);
        end
        tick();  // cycle 5
        tests++;
        if ({done, done_id, result, gnt} !== 9'b1_11_11_1000) begin
            fails++; $display("FAIL drop_done: got %b exp %b", {done, done_id, result, gnt}, 9'b1_11_11_1000);
        end
        tick();  // cycle 6
        tests++;
        if ({done, busy, gnt} !== 6'b0) begin
            fails++; $display("FAIL drop_idle: got %b exp %b", {done, busy, gnt}, 6'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_pass();
        test_simultaneous();
        test_timeout(8'd3, 6, "timeout_t3");
        test_timeout(8'd0, 3, "timeout_t0");
        test_round_robin();
        test_reset_mid_wait();
        test_request_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
